// File: rtl/sram_port_arbiter.sv
// Round-robin arbiter for the shared main-memory SRAM port with lock, starvation
// preemption and owner-tagged read returns that survive grant handover.
module sram_port_arbiter #(
  parameter int NUM_REQ        = 3,
  parameter int ADDR_BUS_WIDTH = 64,
  parameter int DATA_BUS_WIDTH = 64,
  parameter int READ_LATENCY   = 1,
  parameter int MAX_HOLD       = 16,
  parameter int ID_WIDTH       = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic [NUM_REQ-1:0]                           req,
  input  logic [NUM_REQ-1:0]                           lock,
  output logic [NUM_REQ-1:0]                           gnt,
  input  logic [NUM_REQ-1:0]                           req_CEN,
  input  logic [NUM_REQ-1:0]                           req_GWEN,
  input  logic [NUM_REQ-1:0][ADDR_BUS_WIDTH-1:0]       req_A,
  input  logic [NUM_REQ-1:0][DATA_BUS_WIDTH-1:0]       req_D,
  output logic [DATA_BUS_WIDTH-1:0]                    q_out,
  output logic [NUM_REQ-1:0]                           q_valid,
  output logic [ID_WIDTH-1:0]                          owner,
  output logic                                         busy,
  output logic                                         mem_sram_CEN,
  output logic                                         mem_sram_GWEN,
  output logic [ADDR_BUS_WIDTH-1:0]                    mem_sram_A,
  output logic [DATA_BUS_WIDTH-1:0]                    mem_sram_D,
  input  logic [DATA_BUS_WIDTH-1:0]                    mem_sram_Q
);

  localparam int HOLD_W = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = (MAX_HOLD > 0) ? HOLD_W'(MAX_HOLD - 1) : '0;

  typedef enum logic {IDLE, GRANTED} state_t;

  state_t              state;
  logic [ID_WIDTH-1:0] rr_ptr, win;
  logic [HOLD_W-1:0]   hold;
  logic [NUM_REQ-1:0]  gnt_nxt;
  logic                any_req, found, keep, preempt, others, access;
  logic                own_req, own_lock, own_cen, own_gwen;
  int                  idx;

  logic [READ_LATENCY:1]               vld_pipe;
  logic [READ_LATENCY:1][ID_WIDTH-1:0] id_pipe;

  function automatic logic [ID_WIDTH-1:0] rr_next(input logic [ID_WIDTH-1:0] id);
    return (int'(id) == NUM_REQ - 1) ? '0 : id + 1'b1;
  endfunction

  // first requester at or after rr_ptr, wrapping
  always_comb begin
    win   = rr_ptr;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(rr_ptr) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = ID_WIDTH'(idx);
      end
    end
  end

  assign any_req  = |req;
  assign gnt_nxt  = NUM_REQ'(1) << win;
  assign own_req  = req[owner];
  assign own_lock = lock[owner];
  assign own_cen  = req_CEN[owner];
  assign own_gwen = req_GWEN[owner];
  assign others   = |(req & ~gnt);
  assign preempt  = (MAX_HOLD != 0) && (hold == HOLD_LAST) && others && !own_lock;
  assign keep     = (own_req | own_lock) & ~preempt;
  assign access   = gnt[owner] & own_req & ~own_cen;
  assign busy     = |gnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      gnt    <= '0;
      owner  <= '0;
      rr_ptr <= '0;
      hold   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            state  <= GRANTED;
            gnt    <= gnt_nxt;
            owner  <= win;
            rr_ptr <= rr_next(win);
            hold   <= '0;
          end
        end
        GRANTED: begin
          if (keep) begin
            if (hold != HOLD_LAST) hold <= hold + 1'b1;
          end else if (any_req) begin
            // a release or preemption always hands off; the old owner cannot win here
            gnt    <= gnt_nxt;
            owner  <= win;
            rr_ptr <= rr_next(win);
            hold   <= '0;
          end else begin
            state <= IDLE;
            gnt   <= '0;
          end
        end
        default: begin
          state <= IDLE;
          gnt   <= '0;
        end
      endcase
    end
  end

  assign mem_sram_CEN  = ~access;
  assign mem_sram_GWEN = access ? own_gwen : 1'b1;
  assign mem_sram_A    = access ? req_A[owner] : '0;
  assign mem_sram_D    = access ? req_D[owner] : '0;

  // read-return tags travel with the SRAM latency, independent of later grants
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe <= '0;
      id_pipe  <= '0;
    end else begin
      vld_pipe[1] <= access & own_gwen;
      id_pipe[1]  <= owner;
      for (int s = 2; s <= READ_LATENCY; s++) begin
        vld_pipe[s] <= vld_pipe[s-1];
        id_pipe[s]  <= id_pipe[s-1];
      end
    end
  end

  assign q_valid = vld_pipe[READ_LATENCY] ? (NUM_REQ'(1) << id_pipe[READ_LATENCY]) : '0;
  assign q_out   = vld_pipe[READ_LATENCY] ? mem_sram_Q : '0;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed scenarios plus random traffic against a cycle-level reference model
// of the arbiter's grant, access and read-return rules.
module tb_sram_port_arbiter;

  localparam int N  = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int RL = 3;
  localparam int MH = 4;
  localparam int IW = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N-1:0] req, lock, gnt, req_CEN, req_GWEN, q_valid;
  logic [N-1:0][AW-1:0] req_A;
  logic [N-1:0][DW-1:0] req_D;
  logic [DW-1:0] q_out, mem_sram_D, mem_sram_Q;
  logic [AW-1:0] mem_sram_A;
  logic [IW-1:0] owner;
  logic busy, mem_sram_CEN, mem_sram_GWEN;

  sram_port_arbiter #(
    .NUM_REQ(N), .ADDR_BUS_WIDTH(AW), .DATA_BUS_WIDTH(DW),
    .READ_LATENCY(RL), .MAX_HOLD(MH), .ID_WIDTH(IW)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .lock(lock), .gnt(gnt),
    .req_CEN(req_CEN), .req_GWEN(req_GWEN), .req_A(req_A), .req_D(req_D),
    .q_out(q_out), .q_valid(q_valid), .owner(owner), .busy(busy),
    .mem_sram_CEN(mem_sram_CEN), .mem_sram_GWEN(mem_sram_GWEN),
    .mem_sram_A(mem_sram_A), .mem_sram_D(mem_sram_D), .mem_sram_Q(mem_sram_Q)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model: who holds the port, for how many cycles, pending returns
  typedef struct { int due; int id; } ret_t;
  ret_t rq[$];
  bit   m_gr;
  int   m_own, m_rr, m_held, cyc_n;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_gr = 1'b0; m_own = 0; m_rr = 0; m_held = 0;
    rq.delete();
  endtask

  function automatic int rr_winner();
    for (int i = 0; i < N; i++)
      if (req[(m_rr + i) % N]) return (m_rr + i) % N;
    return -1;
  endfunction

  task automatic m_grant(input int w);
    m_gr = 1'b1; m_own = w; m_rr = (w + 1) % N; m_held = 0;
  endtask

  task automatic eval();
    logic [N-1:0] eg, eqv;
    logic [DW-1:0] eqo;
    bit acc, others, pre;
    int w;
    if (rst) m_reset();
    eg  = m_gr ? (N'(1) << m_own) : '0;
    acc = m_gr && req[m_own] && !req_CEN[m_own];
    eqv = '0;
    eqo = '0;
    if (rq.size() > 0 && rq[0].due == cyc_n) begin
      eqv = N'(1) << rq[0].id;
      eqo = mem_sram_Q;
      void'(rq.pop_front());
    end
    chk("gnt",   gnt, eg);
    chk("busy",  busy, |eg);
    chk("owner", owner, m_own);
    chk("cen",   mem_sram_CEN, !acc);
    chk("gwen",  mem_sram_GWEN, acc ? req_GWEN[m_own] : 1'b1);
    chk("addr",  mem_sram_A, acc ? req_A[m_own] : '0);
    chk("wdata", mem_sram_D, acc ? req_D[m_own] : '0);
    chk("qv",    q_valid, eqv);
    chk("qout",  q_out, eqo);
    if (!rst) begin
      if (acc && req_GWEN[m_own]) rq.push_back('{due: cyc_n + RL, id: m_own});
      w = rr_winner();
      if (m_gr) begin
        m_held++;
        others = |(req & ~eg);
        pre = (MH != 0) && (m_held >= MH) && others && !lock[m_own];
        if ((req[m_own] || lock[m_own]) && !pre) begin
        end else if (w >= 0) m_grant(w);
        else m_gr = 1'b0;
      end else if (w >= 0) m_grant(w);
    end
    cyc_n++;
  endtask

  task automatic cycle();
    @(negedge clk);
    eval();
    @(posedge clk);
    #1;
    mem_sram_Q = $urandom;
  endtask

  task automatic idle(input int n);
    req = '0; lock = '0;
    repeat (n) cycle();
  endtask

  int order[$];
  logic [N-1:0] prevg;
  int cnt;

  initial begin
    req = '0; lock = '0; req_CEN = '1; req_GWEN = '1;
    req_A = '0; req_D = '0; mem_sram_Q = '0;
    m_reset(); cyc_n = 0;

    // contention from reset: every requester releases after two granted cycles
    req = '1; req_CEN = '0; req_GWEN = '0;
    for (int i = 0; i < N; i++) begin
      req_A[i] = AW'(32'h1000 * (i + 1));
      req_D[i] = DW'(32'hD00 + i);
    end
    cycle();
    cycle();
    rst = 1'b0;
    prevg = '0;
    repeat (14) begin
      for (int i = 0; i < N; i++) req[i] = !(m_gr && m_own == i && m_held == 2);
      cycle();
      if (gnt != '0 && gnt != prevg) order.push_back(int'(owner));
      prevg = gnt;
    end
    chk("order_len", 64'(order.size() >= 4), 64'd1);
    for (int i = 0; i < 4 && i < order.size(); i++)
      chk("order", 64'(order[i]), 64'(i % N));
    idle(3);

    // single read by requester 1
    req[1] = 1'b1; req_GWEN[1] = 1'b1; req_CEN[1] = 1'b0; req_A[1] = 'h40;
    cycle();
    chk("sr_gnt", gnt, 3'b010);
    chk("sr_addr", mem_sram_A, 'h40);
    chk("sr_cen", mem_sram_CEN, 1'b0);
    cycle();
    req[1] = 1'b0;
    cycle();
    cycle();
    mem_sram_Q = 'hABCD;
    #1;
    chk("sr_qv", q_valid, 3'b010);
    chk("sr_q", q_out, 'hABCD);
    idle(3);

    // lock keeps the grant while req is low
    req[0] = 1'b1; req_GWEN[0] = 1'b0;
    cycle();
    cycle();
    req[0] = 1'b0; lock[0] = 1'b1; req[1] = 1'b1;
    repeat (3) begin
      cycle();
      chk("lk_hold", gnt, 3'b001);
    end
    lock[0] = 1'b0;
    cycle();
    chk("lk_next", gnt, 3'b010);
    idle(3);

    // preemption after MAX_HOLD granted cycles
    req[0] = 1'b1;
    cycle();
    cnt = 0;
    for (int t = 0; t < 20; t++) begin
      if (gnt != 3'b001) break;
      cnt++;
      if (t == 1) req[2] = 1'b1;
      cycle();
    end
    chk("pre_cycles", 64'(cnt), 64'd4);
    chk("pre_next", gnt, 3'b100);
    idle(3);

    // lock blocks preemption
    req[0] = 1'b1; lock[0] = 1'b1;
    cycle();
    req[2] = 1'b1;
    cnt = 0;
    repeat (8) begin
      cycle();
      if (gnt == 3'b001) cnt++;
    end
    chk("lkpre_cycles", 64'(cnt), 64'd8);
    lock[0] = 1'b0;
    cycle();
    chk("lkpre_next", gnt, 3'b100);
    idle(3);

    // read return lands after the grant has moved on
    req[0] = 1'b1; req_GWEN[0] = 1'b1; req_A[0] = 'h100;
    cycle();
    cycle();
    req[0] = 1'b0; req[1] = 1'b1; req_GWEN[1] = 1'b0;
    cycle();
    cycle();
    chk("ho_qv", q_valid, 3'b001);
    chk("ho_gnt", gnt, 3'b010);
    idle(4);

    // asynchronous reset while a read is in flight
    req[1] = 1'b1; req_GWEN[1] = 1'b1;
    cycle();
    cycle();
    rst = 1'b1; req = '0;
    #1;
    chk("rs_gnt", gnt, '0);
    chk("rs_cen", mem_sram_CEN, 1'b1);
    chk("rs_owner", owner, '0);
    cycle();
    rst = 1'b0;
    cnt = 0;
    repeat (RL + 1) begin
      cycle();
      if (q_valid != '0) cnt++;
    end
    chk("rs_noret", 64'(cnt), 64'd0);

    // random traffic
    repeat (600) begin
      req      = N'($urandom);
      lock     = ($urandom_range(0, 7) == 0) ? N'($urandom) : '0;
      req_CEN  = N'($urandom) & N'($urandom);
      req_GWEN = N'($urandom);
      for (int i = 0; i < N; i++) begin
        req_A[i] = $urandom;
        req_D[i] = $urandom;
      end
      cycle();
    end
    idle(RL + 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sram_port_arbiter.md
# sram_port_arbiter

Parametrised N-requester arbiter for the single main-memory SRAM port in the octree accelerator. It replaces the static select-driven SRAM mux. Searcher, updater and further engines (e.g. a DMA loader) request the port. The block grants access round-robin, supports locked atomic sequences and starvation preemption, and returns read data tagged to the requester that issued the read, even after the grant has moved on.

## Interface
Parameters:
- NUM_REQ, 3, number of requesters (≥2)
- ADDR_BUS_WIDTH, 64, SRAM address width
- DATA_BUS_WIDTH, 64, SRAM data width
- READ_LATENCY, 1, cycles from read access (CEN=0, GWEN=1) to valid mem_sram_Q (≥1)
- MAX_HOLD, 16, max consecutive granted cycles before preemption if others wait; 0 disables
- ID_WIDTH, max(1, $clog2(NUM_REQ)), owner index width

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous active-high reset
- req  in  NUM_REQ  per-requester port request
- lock  in  NUM_REQ  hold grant even with req low (atomic read-modify-write)
- gnt  out  NUM_REQ  registered one-hot (or zero) grant
- req_CEN  in  NUM_REQ  per-requester chip enable, active low
- req_GWEN  in  NUM_REQ  per-requester 0 write / 1 read
- req_A  in  NUM_REQ×ADDR_BUS_WIDTH  per-requester address
- req_D  in  NUM_REQ×DATA_BUS_WIDTH  per-requester write data
- q_out  out  DATA_BUS_WIDTH  read data, broadcast
- q_valid  out  NUM_REQ  one-hot: q_out belongs to this requester this cycle
- owner  out  ID_WIDTH  current/last owner index
- busy  out  1  gnt non-zero
- mem_sram_CEN, mem_sram_GWEN  out  1  SRAM controls
- mem_sram_A  out  ADDR_BUS_WIDTH; mem_sram_D  out  DATA_BUS_WIDTH
- mem_sram_Q  in  DATA_BUS_WIDTH  SRAM read data

## Operation
- States: IDLE (gnt=0), GRANTED (gnt=onehot(owner)).
- Next owner: computed from the sampled req. Priority search starts at rr_ptr = (last owner + 1) mod NUM_REQ. rr_ptr=0 after reset.
- IDLE → GRANTED when any req is high. The winner is the first high req at or after rr_ptr.
- GRANTED keeps owner while (req[owner] | lock[owner]) and not preempted.
- Otherwise: move to the next RR winner (GRANTED → GRANTED). If no req is high, go to IDLE.
- Preempt: MAX_HOLD≠0, hold counter == MAX_HOLD−1, some other req high, lock[owner] low.
- The hold counter resets on owner change and saturates.
- lock[owner] blocks preemption and keeps the grant even with req low.
- Effective access: access = gnt[owner] & req[owner] & ~req_CEN[owner].
- During access, the SRAM outputs mirror the owner's signals. Otherwise mem_sram_CEN=1, GWEN=1, A=0, D=0. Non-owner signals are ignored.
- Read tracking: shift register of READ_LATENCY stages {valid, id}. A stage is pushed when access & GWEN=1.
- On stage exit: q_valid[id]=1, q_out=mem_sram_Q. Otherwise q_valid=0 and q_out=0.
- Returns are independent of the current grant.
- Writes produce no return.

## Timing
- Reset values: gnt=0, busy=0, owner=0, q_valid=0, q_out=0, mem_sram_CEN=1, GWEN=1, A=0, D=0. Read pipeline cleared, hold counter=0, rr_ptr=0.
- Grant latency: req high at edge k → gnt at k+1. The first access is possible in cycle k+1.
- Release: req[owner] sampled low at edge k (lock low). In that cycle no access occurs. New gnt (or 0) at k+1, so there is a one-cycle bubble.
- Preemption: gnt drops after exactly MAX_HOLD granted cycles. The preempted requester keeps req high and is re-served in RR order.
- Read return: access at cycle k → q_valid at cycle k+READ_LATENCY. Back-to-back reads give one return per cycle.
- Simultaneous requests: resolved strictly by rr_ptr, never by index alone except after reset.
- Reset mid-operation: immediate (asynchronous). In-flight reads are discarded, with no q_valid after deassertion.
- A grant to a requester whose req falls the same cycle the grant arrives: treat as a release (bubble), with no access.

## Test plan
- Single read: req[1]=1 at edge 0, A=0x40, GWEN=1 → gnt=3'b010 at 1, mem_sram_A=0x40, CEN=0. With mem_sram_Q=0xABCD, q_valid=3'b010 and q_out=0xABCD one cycle later.
- Contention: all req high from reset, each holds 2 cycles → grant order 0,1,2,0. One bubble cycle at each handover.
- Lock: owner 0 drops req with lock[0]=1, req[1] pending → gnt stays 3'b001 until lock[0] falls, then 3'b010 one cycle after.
- Preemption: MAX_HOLD=4, req[0] continuous, req[2] from cycle 2 → gnt[0] for exactly 4 cycles, then gnt=3'b100. With lock[0]=1, no preemption.
- Return across handover: READ_LATENCY=3, requester 0 reads then releases, requester 1 granted → q_valid=3'b001 at issue+3 while gnt=3'b010.
- Reset mid-read: rst pulsed one cycle after a read issue → all outputs at reset values, no q_valid in the following READ_LATENCY cycles.
